// File: rtl/spi_slave_control_if.sv
// rtl/spi_slave_control_if.sv - SPI pin bundle between an external master and spi_slave_control
interface spi_slave_control_if;
  logic SPI_SCLK;
  logic SPI_SS_N;
  logic SPI_MOSI;
  logic SPI_MISO;
  logic SPI_MISO_OE;

  modport slave (
    input  SPI_SCLK,
    input  SPI_SS_N,
    input  SPI_MOSI,
    output SPI_MISO,
    output SPI_MISO_OE
  );

  modport master (
    output SPI_SCLK,
    output SPI_SS_N,
    output SPI_MOSI,
    input  SPI_MISO,
    input  SPI_MISO_OE
  );
endinterface

// File: rtl/spi_slave_control.sv
// rtl/spi_slave_control.sv - SPI slave word engine with oversampled SCLK/SS_N/MOSI
// Optional SPI_SLAVE_ECHO_EN: each word transmits the previously received word.
module spi_slave_control #(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  spi_slave_control_if.slave    spi,
  input  logic [DATA_WIDTH-1:0] data_to_master,
  output logic [DATA_WIDTH-1:0] data_from_master,
  output logic                  successfully,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, drive_edge, ss_fall;
  logic [DATA_WIDTH-1:0]  tx_shift, rx_shift, load_word;
  logic [CNT_W-1:0]       bit_cnt;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = (sclk_s != CPOL) && (sclk_d == CPOL);
  assign trail_edge  = (sclk_s == CPOL) && (sclk_d != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = !ss_s && ss_d;
  assign busy        = (state != IDLE);

`ifdef SPI_SLAVE_ECHO_EN
  assign load_word = data_from_master;
`else
  assign load_word = data_to_master;
`endif

  // SS_N synchroniser resets to "selected" so a select held low across reset
  // produces no falling edge; a fresh high-then-low is needed to start a frame.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= CPOL;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SPI_SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SPI_SS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.SPI_MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state            <= IDLE;
      tx_shift         <= '0;
      rx_shift         <= '0;
      bit_cnt          <= '0;
      spi.SPI_MISO     <= 1'b0;
      spi.SPI_MISO_OE  <= 1'b0;
      data_from_master <= '0;
      successfully     <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      successfully <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          spi.SPI_MISO_OE <= 1'b0;
          if (ss_fall) state <= LOAD;
        end
        LOAD: begin
          tx_shift        <= load_word;
          bit_cnt         <= '0;
          spi.SPI_MISO_OE <= 1'b1;
          if (!CPHA) spi.SPI_MISO <= load_word[DATA_WIDTH-1];
          state           <= SHIFT;
        end
        SHIFT: begin
          // Deselect takes priority over a coincident sample edge.
          if (ss_s) begin
            state           <= IDLE;
            spi.SPI_MISO_OE <= 1'b0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                data_from_master <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                successfully     <= 1'b1;
                state            <= DONE;
              end
            end
            // In mode CPHA=0 the MSB is already on the pin from LOAD, so the
            // trailing edge before the first sample must not advance the shifter.
            if (drive_edge && (CPHA || bit_cnt != '0)) begin
              spi.SPI_MISO <= CPHA ? tx_shift[DATA_WIDTH-1] : tx_shift[DATA_WIDTH-2];
              tx_shift     <= tx_shift << 1;
            end
          end
        end
        default: begin
          if (ss_s) begin
            state           <= IDLE;
            spi.SPI_MISO_OE <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_control.sv
// tb/tb_spi_slave_control.sv - scoreboard bench for spi_slave_control (mode 0 and mode 3 instances)
module tb_spi_slave_control;
`ifdef SPI_SLAVE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic I_CLK = 1'b0;
  logic I_RESETN = 1'b0;
  always #5 I_CLK = ~I_CLK;

  spi_slave_control_if ifa ();
  spi_slave_control_if ifb ();

  logic       m_sclk = 1'b0, m_ss = 1'b1, m_mosi = 1'b0, use_b = 1'b0;
  logic       miso;
  logic [7:0] dtm_a = 8'h00, dtm_b = 8'h00, dfm_a, dfm_b;
  logic       succ_a, ferr_a, busy_a, succ_b, ferr_b, busy_b;
  bit         cur_cpol = 1'b0, cur_cpha = 1'b0;

  assign ifa.SPI_SCLK = use_b ? 1'b0 : m_sclk;
  assign ifa.SPI_SS_N = use_b ? 1'b1 : m_ss;
  assign ifa.SPI_MOSI = m_mosi;
  assign ifb.SPI_SCLK = use_b ? m_sclk : 1'b1;
  assign ifb.SPI_SS_N = use_b ? m_ss : 1'b1;
  assign ifb.SPI_MOSI = m_mosi;
  assign miso = use_b ? ifb.SPI_MISO : ifa.SPI_MISO;

  spi_slave_control #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut_a (
    .I_CLK(I_CLK), .I_RESETN(I_RESETN), .spi(ifa.slave), .data_to_master(dtm_a),
    .data_from_master(dfm_a), .successfully(succ_a), .frame_err(ferr_a), .busy(busy_a));

  spi_slave_control #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut_b (
    .I_CLK(I_CLK), .I_RESETN(I_RESETN), .spi(ifb.slave), .data_to_master(dtm_b),
    .data_from_master(dfm_b), .successfully(succ_b), .frame_err(ferr_b), .busy(busy_b));

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_rx_a[$], exp_rx_b[$], exp_err_a[$], exp_m[$], act_m[$];
  logic [7:0] prev_a = 8'h00, prev_b = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual pulse required none", name);
  endtask

  always @(negedge I_CLK) begin
    if (I_RESETN) begin
      if (succ_a) begin
        if (exp_rx_a.size() == 0) unexpected("successfully_a");
        else check("data_from_master_a", dfm_a, exp_rx_a.pop_front());
      end
      if (ferr_a) begin
        if (exp_err_a.size() == 0) unexpected("frame_err_a");
        else check("data_from_master_kept_a", dfm_a, exp_err_a.pop_front());
      end
      if (succ_b) begin
        if (exp_rx_b.size() == 0) unexpected("successfully_b");
        else check("data_from_master_b", dfm_b, exp_rx_b.pop_front());
      end
      if (ferr_b) unexpected("frame_err_b");
      if (act_m.size() != 0) begin
        if (exp_m.size() == 0) unexpected("master_rx_extra");
        else check("master_rx", act_m.pop_front(), exp_m.pop_front());
      end
    end
  end

  task automatic half();
    repeat (4) @(posedge I_CLK);
    #1;
  endtask

  task automatic start_sel();
    m_ss = 1'b0;
    half();
    half();
  endtask

  task automatic end_sel();
    m_ss = 1'b1;
    half();
    half();
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit chg,
                      input logic [7:0] dtm_new, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cur_cpha) begin
        m_mosi = tx[i];
        half();
        rx[i] = miso;
        m_sclk = ~cur_cpol;
        half();
        m_sclk = cur_cpol;
      end else begin
        m_sclk = ~cur_cpol;
        m_mosi = tx[i];
        half();
        rx[i] = miso;
        m_sclk = cur_cpol;
        half();
      end
      if (chg && i == 4) begin
        if (use_b) dtm_b = dtm_new;
        else dtm_a = dtm_new;
      end
    end
    half();
  endtask

  task automatic word_a(input logic [7:0] tx, input bit chg, input logic [7:0] dtm_new);
    logic [7:0] rx;
    exp_rx_a.push_back(tx);
    exp_m.push_back(ECHO ? prev_a : dtm_a);
    xfer(tx, 8, chg, dtm_new, rx);
    act_m.push_back(rx);
    prev_a = tx;
  endtask

  task automatic do_reset();
    @(posedge I_CLK);
    #1 I_RESETN = 1'b0;
    repeat (3) @(posedge I_CLK);
    #1 I_RESETN = 1'b1;
    prev_a = 8'h00;
    prev_b = 8'h00;
    half();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    repeat (3) @(posedge I_CLK);
    #1;
    check("reset_dfm_a", dfm_a, 8'h00);
    check("reset_successfully_a", succ_a, 1'b0);
    check("reset_frame_err_a", ferr_a, 1'b0);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_miso_a", ifa.SPI_MISO, 1'b0);
    check("reset_miso_oe_a", ifa.SPI_MISO_OE, 1'b0);
    check("reset_dfm_b", dfm_b, 8'h00);
    I_RESETN = 1'b1;
    half();

    // Back-to-back words in one select, data_to_master changed mid-word.
    dtm_a = 8'h5A;
    start_sel();
    check("busy_in_frame", busy_a, 1'b1);
    check("miso_oe_in_frame", ifa.SPI_MISO_OE, 1'b1);
    word_a(8'h11, 1'b1, 8'hC3);
    word_a(8'h22, 1'b0, 8'h00);
    end_sel();
    check("dfm_after_two_words", dfm_a, 8'h22);

    // Single mode-0 word.
    dtm_a = 8'h3C;
    start_sel();
    word_a(8'hA5, 1'b0, 8'h00);
    end_sel();
    check("miso_oe_after_deselect", ifa.SPI_MISO_OE, 1'b0);
    check("busy_after_deselect", busy_a, 1'b0);

    // Deselect after 5 bits.
    start_sel();
    exp_err_a.push_back(prev_a);
    xfer(8'hF0, 5, 1'b0, 8'h00, rx);
    end_sel();
    check("dfm_after_abort", dfm_a, 8'hA5);
    check("miso_oe_after_abort", ifa.SPI_MISO_OE, 1'b0);

    // Reset in the middle of a frame.
    start_sel();
    xfer(8'h0F, 3, 1'b0, 8'h00, rx);
    I_RESETN = 1'b0;
    #1;
    check("midreset_dfm", dfm_a, 8'h00);
    check("midreset_successfully", succ_a, 1'b0);
    check("midreset_frame_err", ferr_a, 1'b0);
    check("midreset_busy", busy_a, 1'b0);
    check("midreset_miso", ifa.SPI_MISO, 1'b0);
    check("midreset_miso_oe", ifa.SPI_MISO_OE, 1'b0);
    m_ss = 1'b1;
    m_sclk = 1'b0;
    repeat (3) @(posedge I_CLK);
    #1 I_RESETN = 1'b1;
    prev_a = 8'h00;
    prev_b = 8'h00;
    half();
    dtm_a = 8'h81;
    start_sel();
    word_a(8'h7E, 1'b0, 8'h00);
    end_sel();

    // CPOL=1, CPHA=1 instance.
    cur_cpol = 1'b1;
    cur_cpha = 1'b1;
    m_sclk = 1'b1;
    use_b = 1'b1;
    dtm_b = 8'h69;
    half();
    start_sel();
    exp_rx_b.push_back(8'h96);
    exp_m.push_back(ECHO ? prev_b : dtm_b);
    xfer(8'h96, 8, 1'b0, 8'h00, rx);
    act_m.push_back(rx);
    prev_b = 8'h96;
    end_sel();

    // Two separate frames after reset (echo behaviour visible when enabled).
    cur_cpol = 1'b0;
    cur_cpha = 1'b0;
    m_sclk = 1'b0;
    use_b = 1'b0;
    do_reset();
    dtm_a = 8'h55;
    start_sel();
    word_a(8'h12, 1'b0, 8'h00);
    end_sel();
    start_sel();
    word_a(8'h34, 1'b0, 8'h00);
    end_sel();

    for (int k = 0; k < 200 && act_m.size() != 0; k++) @(posedge I_CLK);
    check("pending_master_rx", act_m.size(), 0);
    check("pending_successfully_a", exp_rx_a.size(), 0);
    check("pending_successfully_b", exp_rx_b.size(), 0);
    check("pending_frame_err_a", exp_err_a.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_control.md
Name: spi_slave_control

Overview:
SPI slave-side byte engine, the counterpart of the master-side sequencer. It receives SPI_SCLK, SPI_SS_N and SPI_MOSI from an external master and drives SPI_MISO. It exchanges DATA_WIDTH-bit words: one word shifts in while data_to_master shifts out. All SPI inputs are oversampled in the I_CLK domain, and each completed word is reported with a one-cycle successfully pulse.

Parameters:
DATA_WIDTH, 8, word length in bits, shifted MSB first
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
SYNC_STAGES, 2, synchroniser depth on SCLK/SS_N/MOSI, minimum 2

Ports:
I_CLK  in  1  system clock
I_RESETN  in  1  reset, asynchronous, active-low
SPI_SCLK  in  1  serial clock from master, asynchronous to I_CLK
SPI_SS_N  in  1  slave select, active-low
SPI_MOSI  in  1  serial data from master
SPI_MISO  out  1  serial data to master
SPI_MISO_OE  out  1  MISO output enable; 1 only while selected
data_to_master  in  DATA_WIDTH  word to transmit; sampled at each word load
data_from_master  out  DATA_WIDTH  last complete received word
successfully  out  1  one-cycle pulse when a word completes
frame_err  out  1  one-cycle pulse on a deselect in mid-word
busy  out  1  high in every state except IDLE

Behaviour:
- One clock, I_CLK. Reset is asynchronous and active-low on I_RESETN.
- Reset values: SPI_MISO=0, SPI_MISO_OE=0, data_from_master=0, successfully=0, frame_err=0, busy=0. Shift registers and bit counter clear; state=IDLE.
- Synchronisation and edge detection:
  - SCLK, SS_N and MOSI each pass through SYNC_STAGES flops.
  - Edges come from the synchronised value against a one-cycle-delayed copy.
  - Leading edge = SCLK leaving CPOL; trailing edge = SCLK returning to CPOL.
- Timing constraints (stated, not checked):
  - SCLK high and low time each ≥ SYNC_STAGES+2 I_CLK periods.
  - SS_N fall to first SCLK edge ≥ SYNC_STAGES+2 I_CLK periods.
- State machine:
  - IDLE: MISO_OE=0. Synchronised SS_N falling -> LOAD.
  - LOAD (1 cycle): tx_shift <= data_to_master; bit_cnt <= 0; MISO_OE <= 1. If CPHA=0, SPI_MISO <= data_to_master[MSB]. Next state SHIFT.
  - SHIFT:
    - Sample edge (leading if CPHA=0, trailing if CPHA=1): rx_shift <= {rx_shift, MOSI_sync}; bit_cnt++.
    - Drive edge (the other edge): SPI_MISO <= next tx bit. For CPHA=1 the first leading edge drives the MSB.
    - After the DATA_WIDTH-th sample -> DONE.
  - DONE (1 cycle): data_from_master <= rx_shift; successfully=1. If SS_N is still low -> LOAD (back-to-back word). Otherwise -> IDLE.
- Deselect handling:
  - SS_N rising in SHIFT with 0 < bit_cnt < DATA_WIDTH: go to IDLE, pulse frame_err for one cycle, leave data_from_master unchanged, set MISO_OE=0.
  - SS_N rising in SHIFT with bit_cnt=0: go to IDLE silently, no pulse.
- A sample edge and an SS_N rise in the same cycle: the deselect wins and the sample is discarded.
- Latency: last sample edge (synchronised) to successfully = 1 cycle. Overall SCLK pin edge to successfully = SYNC_STAGES+2 cycles.
- SCLK edges while in IDLE are ignored.
- Reset asserted mid-frame: everything returns to reset values immediately, with no successfully or frame_err pulse. After reset release, the block waits for a fresh SS_N falling edge. If SS_N is already low at release, no frame starts until SS_N goes high and then falls again.
- bit_cnt width is clog2(DATA_WIDTH)+1 and never wraps. When not in DONE, successfully=0.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: LOAD loads tx_shift from the previous data_from_master instead of data_to_master. The first word after reset transmits 0. data_to_master is ignored.
- Undefined: LOAD uses data_to_master as described above.

Test Plan:
1. Mode 0, data_to_master=0x3C, master sends 0xA5 at SCLK = I_CLK/8 -> data_from_master=0xA5; master receives 0x3C; exactly one successfully pulse; frame_err=0.
2. One SS_N assertion carrying 0x11 then 0x22, with data_to_master changed 0x5A->0xC3 between words -> two successfully pulses; data_from_master ends at 0x22; master receives 0x5A, 0xC3.
3. SS_N released after 5 SCLK cycles, with data_from_master previously 0xA5 -> frame_err pulses once; no successfully pulse; data_from_master stays 0xA5; MISO_OE=0.
4. I_RESETN asserted after bit 3 of a frame -> all outputs at reset values within the same cycle. After release, a new frame with 0x7E completes correctly.
5. CPOL=1, CPHA=1 instance, master sends 0x96, data_to_master=0x69 -> data_from_master=0x96; master receives 0x69.
6. SPI_SLAVE_ECHO_EN defined: frames 0x12 then 0x34 -> master receives 0x00 then 0x12.
